// File: rtl/conn_weight_loader.sv
// conn_weight_loader: streams `count` Q-format weights into a bank of NUM_CONN
// connection weight registers starting at `base_idx`. Each accepted beat
// produces one registered one-hot `set_en` strobe together with `set_weight`.
// Build option: define CONN_WEIGHT_LOADER_CLAMP_EN to saturate every accepted
// weight to [-CLAMP_MAG, +CLAMP_MAG]; otherwise weights pass through unchanged.
module conn_weight_loader #(
  parameter int FIXED_BITS      = 8,
  parameter int FRACTIONAL_BITS = 8,
  parameter int NUM_CONN        = 16,
  parameter logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0] CLAMP_MAG = 16'sh7FFF,
  localparam int W     = FIXED_BITS + FRACTIONAL_BITS,
  localparam int IDX_W = $clog2(NUM_CONN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [IDX_W-1:0]    base_idx,
  input  logic [IDX_W:0]      count,
  input  logic signed [W-1:0] in_weight,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] set_weight,
  output logic [NUM_CONN-1:0] set_en,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W:0]      loaded_count
);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [IDX_W:0]      remaining_reg, remaining_next;
  logic [IDX_W:0]      loaded_count_reg, loaded_count_next;
  logic signed [W-1:0] set_weight_reg, set_weight_next;
  logic [NUM_CONN-1:0] set_en_reg, set_en_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;

  logic [NUM_CONN-1:0] idx_onehot;
  logic [IDX_W+1:0]    cmd_end;
  logic                cmd_bad;
  logic                accept;
  logic signed [W-1:0] weight_cond;

  // One-hot decode of the current write index.
  for (genvar gi = 0; gi < NUM_CONN; gi++) begin : g_onehot
    assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
  end

  // A command must be non-empty and must end at or before the last connection.
  assign cmd_end = {2'b00, base_idx} + {1'b0, count};
  assign cmd_bad = (count == '0) || (cmd_end > (IDX_W+2)'(NUM_CONN));

  assign in_ready = (state_reg == LOAD) && !abort;
  assign accept   = in_ready && in_valid;

`ifdef CONN_WEIGHT_LOADER_CLAMP_EN
  localparam logic signed [W-1:0] NEG_MAG = -CLAMP_MAG;

  // Saturate the incoming weight symmetrically around zero.
  always_comb begin
    weight_cond = in_weight;
    if (in_weight > CLAMP_MAG)
      weight_cond = CLAMP_MAG;
    else if (in_weight < NEG_MAG)
      weight_cond = NEG_MAG;
  end
`else
  assign weight_cond = in_weight;
`endif

  // State and datapath registers; reset clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      remaining_reg    <= '0;
      loaded_count_reg <= '0;
      set_weight_reg   <= '0;
      set_en_reg       <= '0;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      remaining_reg    <= remaining_next;
      loaded_count_reg <= loaded_count_next;
      set_weight_reg   <= set_weight_next;
      set_en_reg       <= set_en_next;
      done_reg         <= done_next;
      err_reg          <= err_next;
    end
  end

  // Next-state logic: command check in IDLE, one write per accepted beat in LOAD.
  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    remaining_next    = remaining_reg;
    loaded_count_next = loaded_count_reg;
    set_weight_next   = set_weight_reg;
    set_en_next       = '0;
    done_next         = 1'b0;
    err_next          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (cmd_bad) begin
            err_next = 1'b1;
          end else begin
            idx_next          = base_idx;
            remaining_next    = count;
            loaded_count_next = '0;
            state_next        = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (accept) begin
          set_weight_next   = weight_cond;
          set_en_next       = idx_onehot;
          idx_next          = idx_reg + 1'b1;
          remaining_next    = remaining_reg - 1'b1;
          loaded_count_next = loaded_count_reg + 1'b1;
          if (remaining_reg == (IDX_W+1)'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign set_weight   = set_weight_reg;
  assign set_en       = set_en_reg;
  assign busy         = (state_reg == LOAD);
  assign done         = done_reg;
  assign err          = err_reg;
  assign loaded_count = loaded_count_reg;

endmodule
